muldiv_unit: RTL and testbench

Execute-stage multi-cycle multiply/divide unit for MULT/MULTU/DIV/DIVU, producing HI/LO. It is the source of the `e_wait` request that the hazard unit turns into E-stage stall plus M-stage bubble. It consumes that unit's `stallE`/`flushE` replies so that an operation completes exactly once, is held across downstream stalls, and is cancelled cleanly on exception or branch flush.

---
 rtl/muldiv_pkg.sv | 35 +++
 rtl/muldiv_unit_div_iter.sv | 74 +++++++
 rtl/muldiv_unit.sv | 160 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and defaults for the execute-stage multiply/divide unit.
package muldiv_pkg;

   typedef enum logic [1:0] {
      OP_MULT  = 2'd0,
      OP_MULTU = 2'd1,
      OP_DIV   = 2'd2,
      OP_DIVU  = 2'd3
   } muldiv_op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } muldiv_state_t;

   localparam int MUL_LAT_DEFAULT  = 2;
   localparam int DIV_ITER_DEFAULT = 32;
   localparam int RES_WIDTH        = 32;

   typedef struct packed {
      logic [RES_WIDTH-1:0] hi;
      logic [RES_WIDTH-1:0] lo;
   } muldiv_res_t;

   function automatic logic op_is_signed(input muldiv_op_t op);
      return (op == OP_MULT) || (op == OP_DIV);
   endfunction

   function automatic logic op_is_div(input muldiv_op_t op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/muldiv_unit_div_iter.sv
// Restoring divider on unsigned magnitudes: one shift-subtract step per cycle,
// with done high for one cycle after the last step.
module div_iter
   import muldiv_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int DIV_ITER = DIV_ITER_DEFAULT
)
(
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic             abort,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   localparam int CW = $clog2(DIV_ITER + 1);

   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] quo_q;
   logic [WIDTH-1:0] dvs_q;
   logic [CW-1:0]    cnt_q;
   logic             busy_q;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   trial;

   // The extra top bit of trial acts as the borrow: set means "restore".
   always_comb begin
      shifted = {rem_q, quo_q[WIDTH-1]};
      trial   = shifted - {1'b0, dvs_q};
   end

   assign done      = busy_q && (cnt_q == CW'(DIV_ITER));
   assign quotient  = quo_q;
   assign remainder = rem_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rem_q  <= '0;
         quo_q  <= '0;
         dvs_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else if (abort) begin
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else if (start) begin
         rem_q  <= '0;
         quo_q  <= dividend;
         dvs_q  <= divisor;
         cnt_q  <= '0;
         busy_q <= 1'b1;
      end else if (busy_q) begin
         if (cnt_q == CW'(DIV_ITER)) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
         end else begin
            if (!trial[WIDTH]) begin
               rem_q <= trial[WIDTH-1:0];
               quo_q <= {quo_q[WIDTH-2:0], 1'b1};
            end else begin
               rem_q <= shifted[WIDTH-1:0];
               quo_q <= {quo_q[WIDTH-2:0], 1'b0};
            end
            cnt_q <= cnt_q + CW'(1);
         end
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit for the E stage; raises e_wait until
// HI/LO are ready and holds them until the instruction leaves E.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int MUL_LAT  = MUL_LAT_DEFAULT,
   parameter int DIV_ITER = DIV_ITER_DEFAULT
)
(
   input  logic             clk,
   input  logic             resetn,
   input  logic             valid_i,
   input  muldiv_op_t       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             stall_i,
   input  logic             flush_i,
   output logic             e_wait,
   output logic             done_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   // MUL_LAT must be at least 2: one IDLE cycle plus MUL_LAT-1 MUL cycles.
   localparam int MCW = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;

   muldiv_state_t      state_q;
   logic [MCW-1:0]     mul_cnt_q;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic               mul_signed_q;
   logic               q_neg_q;
   logic               r_neg_q;
   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH-1:0]   lo_q;
   logic               done_q;

   logic               in_signed;
   logic               in_div;
   logic               div_zero;
   logic               div_start;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic [2*WIDTH-1:0] ext_a;
   logic [2*WIDTH-1:0] ext_b;
   logic [2*WIDTH-1:0] product;
   logic               div_done;
   logic [WIDTH-1:0]   div_quo;
   logic [WIDTH-1:0]   div_rem;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;

   // Sign-extending only for MULT lets one 2W-bit multiplier serve both ops.
   always_comb begin
      in_signed = op_is_signed(op_i);
      in_div    = op_is_div(op_i);
      div_zero  = (b_i == '0);
      a_mag     = (in_signed && a_i[WIDTH-1]) ? -a_i : a_i;
      b_mag     = (in_signed && b_i[WIDTH-1]) ? -b_i : b_i;
      div_start = (state_q == ST_IDLE) && valid_i && !flush_i && in_div && !div_zero;
      ext_a     = {{WIDTH{mul_signed_q & a_q[WIDTH-1]}}, a_q};
      ext_b     = {{WIDTH{mul_signed_q & b_q[WIDTH-1]}}, b_q};
      product   = ext_a * ext_b;
      quo_fix   = q_neg_q ? -div_quo : div_quo;
      rem_fix   = r_neg_q ? -div_rem : div_rem;
   end

   div_iter #(
      .WIDTH    (WIDTH),
      .DIV_ITER (DIV_ITER)
   ) u_div_iter (
      .clk       (clk),
      .resetn    (resetn),
      .start     (div_start),
      .abort     (flush_i),
      .dividend  (a_mag),
      .divisor   (b_mag),
      .done      (div_done),
      .quotient  (div_quo),
      .remainder (div_rem)
   );

   // HI/LO are written only on entry to DONE, so a flush never disturbs them.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= ST_IDLE;
         mul_cnt_q    <= '0;
         a_q          <= '0;
         b_q          <= '0;
         mul_signed_q <= 1'b0;
         q_neg_q      <= 1'b0;
         r_neg_q      <= 1'b0;
         hi_q         <= '0;
         lo_q         <= '0;
         done_q       <= 1'b0;
      end else if (flush_i) begin
         state_q   <= ST_IDLE;
         mul_cnt_q <= '0;
         done_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (valid_i) begin
                  a_q          <= a_i;
                  b_q          <= b_i;
                  mul_signed_q <= in_signed;
                  q_neg_q      <= in_signed & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                  r_neg_q      <= in_signed & a_i[WIDTH-1];
                  mul_cnt_q    <= '0;
                  if (!in_div) begin
                     state_q <= ST_MUL;
                  end else if (div_zero) begin
                     hi_q    <= a_i;
                     lo_q    <= '1;
                     done_q  <= 1'b1;
                     state_q <= ST_DONE;
                  end else begin
                     state_q <= ST_DIV;
                  end
               end
            end
            ST_MUL: begin
               if (mul_cnt_q == MCW'(MUL_LAT - 2)) begin
                  hi_q      <= product[2*WIDTH-1:WIDTH];
                  lo_q      <= product[WIDTH-1:0];
                  done_q    <= 1'b1;
                  mul_cnt_q <= '0;
                  state_q   <= ST_DONE;
               end else begin
                  mul_cnt_q <= mul_cnt_q + MCW'(1);
               end
            end
            ST_DIV: begin
               if (div_done) begin
                  hi_q    <= rem_fix;
                  lo_q    <= quo_fix;
                  done_q  <= 1'b1;
                  state_q <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (!stall_i) begin
                  done_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign e_wait = valid_i && (state_q != ST_DONE) && !flush_i;
   assign done_o = done_q;
   assign hi_o   = hi_q;
   assign lo_o   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: latency, results, stall hold, flush and reset abort.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        valid_in = 1'b0;
   muldiv_op_t  op_in = OP_MULT;
   logic [31:0] a_in = '0;
   logic [31:0] b_in = '0;
   logic        stall_in = 1'b0;
   logic        flush_in = 1'b0;
   logic        e_wait;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int total = 0;
   int bad = 0;

   muldiv_unit dut (
      .clk     (clk),
      .resetn  (resetn),
      .valid_i (valid_in),
      .op_i    (op_in),
      .a_i     (a_in),
      .b_i     (b_in),
      .stall_i (stall_in),
      .flush_i (flush_in),
      .e_wait  (e_wait),
      .done_o  (done),
      .hi_o    (hi),
      .lo_o    (lo)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are read 1 unit later.
   task automatic applyStimulus(input logic v, input muldiv_op_t op, input logic [31:0] a,
                                input logic [31:0] b, input logic st, input logic fl);
      @(posedge clk);
      #1;
      valid_in = v;
      op_in    = op;
      a_in     = a;
      b_in     = b;
      stall_in = st;
      flush_in = fl;
      #1;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #2;
   endtask

   task automatic runOp(input string tag, input muldiv_op_t op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_wait,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int n;
      int early;
      applyStimulus(1'b1, op, a, b, 1'b0, 1'b0);
      n = 0;
      early = 0;
      while (e_wait === 1'b1 && n < 100) begin
         if (done !== 1'b0) early++;
         n++;
         nextCycle();
         a_in = ~a;
         b_in = ~b;
      end
      checkOutput({tag, " wait"}, 64'(n), 64'(exp_wait));
      checkOutput({tag, " early done"}, 64'(early), 64'd0);
      checkOutput({tag, " done"}, {63'd0, done}, 64'd1);
      checkOutput({tag, " hi"}, {32'd0, hi}, {32'd0, exp_hi});
      checkOutput({tag, " lo"}, {32'd0, lo}, {32'd0, exp_lo});
      applyStimulus(1'b0, op, 32'd0, 32'd0, 1'b0, 1'b0);
   endtask

   initial begin
      int n;

      // Reset state
      #2;
      checkOutput("reset done", {63'd0, done}, 64'd0);
      checkOutput("reset hilo", {hi, lo}, 64'd0);
      checkOutput("reset ewait", {63'd0, e_wait}, 64'd0);
      @(posedge clk);
      #2;
      resetn = 1'b1;

      // Multiply and divide results and latencies
      runOp("mult -2*3", OP_MULT, 32'hFFFF_FFFE, 32'd3, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
      runOp("multu max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFE, 32'h0000_0001);
      runOp("divu 100/7", OP_DIVU, 32'd100, 32'd7, 34, 32'd2, 32'd14);
      runOp("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      runOp("div 7/-2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 34, 32'd1, 32'hFFFF_FFFD);
      runOp("div -9/-4", OP_DIV, 32'hFFFF_FFF7, 32'hFFFF_FFFC, 34, 32'hFFFF_FFFF, 32'd2);
      runOp("div ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'd0, 32'h8000_0000);
      runOp("divu big", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h8000_0000, 32'd0);
      runOp("div by0", OP_DIV, 32'h0000_1234, 32'd0, 1, 32'h0000_1234, 32'hFFFF_FFFF);
      runOp("divu by0", OP_DIVU, 32'hDEAD_BEEF, 32'd0, 1, 32'hDEAD_BEEF, 32'hFFFF_FFFF);

      // DONE held under stall, then a back-to-back MULTU
      applyStimulus(1'b1, OP_MULTU, 32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0);
      n = 0;
      while (e_wait === 1'b1 && n < 100) begin
         n++;
         nextCycle();
      end
      checkOutput("stall wait", 64'(n), 64'd2);
      stall_in = 1'b1;
      for (int i = 0; i < 5; i++) begin
         nextCycle();
         checkOutput($sformatf("stall hold%0d done", i), {63'd0, done}, 64'd1);
         checkOutput($sformatf("stall hold%0d ewait", i), {63'd0, e_wait}, 64'd0);
         checkOutput($sformatf("stall hold%0d hilo", i), {hi, lo}, 64'h0000_0001_0000_0000);
      end
      stall_in = 1'b0;
      runOp("b2b multu", OP_MULTU, 32'd7, 32'd6, 2, 32'd0, 32'd42);

      // Flush in the middle of a divide
      applyStimulus(1'b1, OP_DIV, 32'd1000, 32'd3, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) nextCycle();
      flush_in = 1'b1;
      #1;
      checkOutput("flush ewait", {63'd0, e_wait}, 64'd0);
      applyStimulus(1'b0, OP_DIV, 32'd0, 32'd0, 1'b0, 1'b0);
      checkOutput("flush idle done", {63'd0, done}, 64'd0);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         nextCycle();
         if (done !== 1'b0) n++;
      end
      checkOutput("flush never done", 64'(n), 64'd0);
      checkOutput("flush hilo kept", {hi, lo}, {32'd0, 32'd42});

      // Flush with valid in IDLE starts nothing; flush in MUL, then restart
      applyStimulus(1'b1, OP_MULT, 32'd3, 32'd4, 1'b0, 1'b1);
      checkOutput("flush prio ewait", {63'd0, e_wait}, 64'd0);
      applyStimulus(1'b1, OP_MULT, 32'd3, 32'd4, 1'b0, 1'b0);
      nextCycle();
      flush_in = 1'b1;
      runOp("restart mult", OP_MULT, 32'd5, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFB);

      // Asynchronous reset mid-divide
      applyStimulus(1'b1, OP_DIVU, 32'd100, 32'd7, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) nextCycle();
      resetn = 1'b0;
      #1;
      checkOutput("abort done", {63'd0, done}, 64'd0);
      checkOutput("abort hilo", {hi, lo}, 64'd0);
      checkOutput("abort ewait idle", {63'd0, e_wait}, 64'd1);
      valid_in = 1'b0;
      #1;
      checkOutput("abort ewait novalid", {63'd0, e_wait}, 64'd0);
      @(posedge clk);
      #2;
      resetn = 1'b1;
      runOp("post reset divu", OP_DIVU, 32'd100, 32'd7, 34, 32'd2, 32'd14);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
